// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic {RUN, MD_WAIT} state_e;
  localparam int RF_ADDR_W = 5;
  localparam int PERF_W = 32;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from ID/EX and the pipeline register controls.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic [RF_ADDR_W-1:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_mem_read, ex_md, branch_taken, mem_wait;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, md_busy;
  logic [PERF_W-1:0] stall_cycles, flush_count;
  modport master(
    output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_md, branch_taken, mem_wait,
    input pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, md_busy,
    input stall_cycles, flush_count
  );
  modport slave(
    input id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_md, branch_taken, mem_wait,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, md_busy,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_lat_counter.sv
// md_lat_counter: loadable down-counter with hold and zero flag for mul/div occupancy.
module md_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic         hold_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = hold_i ? cnt_q : load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, branch, mul/div and memory-wait sequencing for the 5-stage pipe.
// Perf counters are built only when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave pipe_io
);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT > 1 ? MD_LAT - 2 : 0);
  state_e state_q, state_d;
  logic cnt_load, cnt_dec, cnt_zero, load_use, md_start;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, md_busy;
  assign load_use = pipe_io.ex_mem_read && pipe_io.ex_rt != REG_ZERO &&
                    (pipe_io.ex_rt == pipe_io.id_rs || (pipe_io.id_uses_rt && pipe_io.ex_rt == pipe_io.id_rt));
  assign md_start = pipe_io.ex_md && (MD_LAT > 1);
  md_lat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load_i(cnt_load), .dec_i(cnt_dec),
    .hold_i(pipe_io.mem_wait), .val_i(MD_LOAD), .zero_o(cnt_zero)
  );
  always_comb begin
    state_d = state_q;
    cnt_load = 1'b0;
    cnt_dec = 1'b0;
    {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
    {ifid_flush, idex_bubble, exmem_bubble} = 3'b000;
    md_busy = !rst && state_q == MD_WAIT;
    if (rst || pipe_io.mem_wait) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
    end else if (state_q == MD_WAIT) begin
      if (!cnt_zero) begin
        {pc_we, ifid_we, idex_we, exmem_bubble} = 4'b0001;
        cnt_dec = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (pipe_io.branch_taken) begin
      {ifid_flush, idex_bubble} = 2'b11;
    end else if (md_start) begin
      {pc_we, ifid_we, idex_we, exmem_bubble} = 4'b0001;
      cnt_load = 1'b1;
      state_d = MD_WAIT;
    end else if (load_use) begin
      {pc_we, ifid_we, idex_bubble} = 3'b001;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= RUN;
    else state_q <= state_d;
  assign pipe_io.pc_we = pc_we;
  assign pipe_io.ifid_we = ifid_we;
  assign pipe_io.ifid_flush = ifid_flush;
  assign pipe_io.idex_we = idex_we;
  assign pipe_io.idex_bubble = idex_bubble;
  assign pipe_io.exmem_we = exmem_we;
  assign pipe_io.exmem_bubble = exmem_bubble;
  assign pipe_io.md_busy = md_busy;
`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (ifid_flush && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  assign pipe_io.stall_cycles = stall_q;
  assign pipe_io.flush_count = flush_q;
`else
  assign pipe_io.stall_cycles = '0;
  assign pipe_io.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus checked against an occupancy-based model.
module tb_pipe_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam logic [7:0] NORM  = 8'b11010100;
  localparam logic [7:0] STALL = 8'b00000110;
  localparam logic [7:0] FLUSH = 8'b11111100;
  localparam logic [7:0] LDUSE = 8'b00011100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit in_md = 0;
  int occ = 0;
  longint stall_n = 0;
  longint flush_n = 0;
  pipe_hazard_ctrl_if hz();
  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut (.clk(clk), .rst(rst), .pipe_io(hz));
  always #5 clk = ~clk;
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit r, mw, br, md, mr, ut, input logic [4:0] rs, rt, xrt);
    rst = r;
    hz.mem_wait = mw;
    hz.branch_taken = br;
    hz.ex_md = md;
    hz.ex_mem_read = mr;
    hz.id_uses_rt = ut;
    hz.id_rs = rs;
    hz.id_rt = rt;
    hz.ex_rt = xrt;
  endtask
  // One pipeline cycle: inputs already driven just after the falling edge.
  task automatic cyc(input string tag);
    logic [7:0] e, got;
    bit lu;
    #1;
    if (rst) begin
      in_md = 0;
      occ = 0;
      stall_n = 0;
      flush_n = 0;
    end
    lu = hz.ex_mem_read && hz.ex_rt != 0 &&
         (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
    if (rst) e = 8'h00;
    else if (hz.mem_wait) e = {7'b0, in_md};
    else if (in_md) e = (occ < MD_LAT - 1 ? STALL : NORM) | 8'h01;
    else if (hz.branch_taken) e = FLUSH;
    else if (hz.ex_md && MD_LAT > 1) e = STALL;
    else if (lu) e = LDUSE;
    else e = NORM;
    got = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_bubble,
           hz.exmem_we, hz.exmem_bubble, hz.md_busy};
    check_val({tag, "_ctl"}, 32'(got), 32'(e));
`ifdef HAZ_PERF_EN
    check_val({tag, "_stall_cycles"}, hz.stall_cycles, 32'(stall_n));
    check_val({tag, "_flush_count"}, hz.flush_count, 32'(flush_n));
`else
    check_val({tag, "_stall_cycles"}, hz.stall_cycles, 32'd0);
    check_val({tag, "_flush_count"}, hz.flush_count, 32'd0);
`endif
    if (!rst) begin
      if (!e[7]) stall_n++;
      if (e[5]) flush_n++;
      if (!hz.mem_wait) begin
        if (in_md) begin
          if (occ < MD_LAT - 1) occ++;
          else in_md = 0;
        end else if (!hz.branch_taken && hz.ex_md && MD_LAT > 1) begin
          in_md = 1;
          occ = 1;
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc("reset0");
    cyc("reset1");
    drive(0, 0, 0, 0, 1, 0, 8, 0, 8); cyc("lduse");
    drive(0, 0, 0, 0, 0, 0, 8, 0, 8); cyc("lduse_after");
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0); cyc("zero_reg");
    drive(0, 0, 0, 0, 1, 1, 3, 8, 8); cyc("lduse_rt");
    drive(0, 0, 0, 0, 1, 0, 3, 8, 8); cyc("rt_unused");
    repeat (4) begin drive(0, 0, 0, 1, 0, 0, 1, 2, 3); cyc("md_hold"); end
    drive(0, 0, 1, 0, 1, 0, 8, 0, 8); cyc("br_lduse");
    drive(0, 0, 1, 1, 0, 0, 1, 2, 3); cyc("br_md");
    drive(0, 0, 0, 0, 0, 0, 1, 2, 3); cyc("idle");
    drive(0, 0, 0, 1, 0, 0, 1, 2, 3); cyc("mw_md0");
    cyc("mw_md1");
    repeat (3) begin drive(0, 1, 0, 1, 0, 0, 1, 2, 3); cyc("mw_hold"); end
    drive(0, 0, 0, 1, 0, 0, 1, 2, 3); cyc("mw_md2");
    cyc("mw_exit");
    drive(0, 0, 0, 0, 0, 0, 1, 2, 3); cyc("idle2");
    drive(0, 0, 0, 1, 0, 0, 1, 2, 3); cyc("rst_md0");
    cyc("rst_md1");
    drive(1, 0, 0, 1, 0, 0, 1, 2, 3); cyc("rst_mid");
    drive(0, 0, 0, 0, 0, 0, 1, 2, 3); cyc("rst_after");
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 15, $urandom_range(99) < 15,
            $urandom_range(99) < 25, $urandom_range(1), $urandom_range(1),
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      cyc("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
